// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and data-memory wait controller for the
// five-stage core.
//   clk_i, rst_i            : clock (rising edge), async active-high reset
//   Rs*/Rd*/RegWrite*       : register indices and writeback enables per stage
//   ResultSrcE_i            : 2'b01 marks a load in execute
//   PCSrcE_i                : taken branch/jump resolved in execute
//   MemAccessM_i, MemAck_i  : M-stage memory access and memory completion pulse
//   MemReqValid_o           : one-cycle request to data memory
//   En*_o, Flush*_o         : pipeline register enables / bubble inserts
//   ForwardAE_o/BE_o        : execute operand mux selects (00 RF, 01 W, 10 M)
//   MemError_o              : sticky memory timeout flag
//   StallCycles_o, FlushCount_o : wrapping performance counters
module hazard_ctrl #(
  parameter int unsigned REGISTER_ADDR_SIZE = 5,
  parameter int unsigned TIMEOUT            = 16,
  parameter int unsigned CNT_WIDTH          = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs1D_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs2D_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs1E_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs2E_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] RdE_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] RdM_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] RdW_i,
  input  logic                          RegWriteM_i,
  input  logic                          RegWriteW_i,
  input  logic [1:0]                    ResultSrcE_i,
  input  logic                          PCSrcE_i,
  input  logic                          MemAccessM_i,
  input  logic                          MemAck_i,
  output logic                          MemReqValid_o,
  output logic                          EnF_o,
  output logic                          EnD_o,
  output logic                          EnE_o,
  output logic                          EnM_o,
  output logic                          FlushD_o,
  output logic                          FlushE_o,
  output logic                          FlushW_o,
  output logic [1:0]                    ForwardAE_o,
  output logic [1:0]                    ForwardBE_o,
  output logic                          MemError_o,
  output logic [CNT_WIDTH-1:0]          StallCycles_o,
  output logic [CNT_WIDTH-1:0]          FlushCount_o
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_d;
  logic              mem_stall;
  logic              lw_stall;
  logic              branch_taken;

  // Forwarding select for one execute operand; M beats W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REGISTER_ADDR_SIZE-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == rs))
      sel = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    ForwardAE_o = fwd_sel(Rs1E_i);
    ForwardBE_o = fwd_sel(Rs2E_i);
  end

  // State register, wait counter and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      MemError_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      MemError_o <= mem_err_d;
    end
  end

  // Memory request/ack sequencing. The request cycle plus TIMEOUT waiting
  // cycles are stalled; the cycle after that releases without an ack.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = MemError_o;
    mem_stall     = 1'b0;
    MemReqValid_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (MemAccessM_i) begin
            MemReqValid_o = 1'b1;
            mem_stall     = 1'b1;
            wait_cnt_d    = '0;
            state_d       = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (MemAck_i) begin
            state_d = ST_IDLE;
          end else if (wait_cnt_q == WCNT_W'(TIMEOUT)) begin
            state_d   = ST_IDLE;
            mem_err_d = 1'b1;
          end else begin
            mem_stall  = 1'b1;
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pipeline enables/flushes: memory stall > taken branch > load-use.
  always_comb begin
    EnF_o        = 1'b1;
    EnD_o        = 1'b1;
    EnE_o        = 1'b1;
    EnM_o        = 1'b1;
    FlushD_o     = 1'b0;
    FlushE_o     = 1'b0;
    FlushW_o     = 1'b0;
    branch_taken = 1'b0;
    lw_stall     = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    if (mem_stall) begin
      EnF_o    = 1'b0;
      EnD_o    = 1'b0;
      EnE_o    = 1'b0;
      EnM_o    = 1'b0;
      FlushW_o = 1'b1;
    end else if (PCSrcE_i) begin
      FlushD_o     = 1'b1;
      FlushE_o     = 1'b1;
      branch_taken = 1'b1;
    end else if (lw_stall) begin
      EnF_o    = 1'b0;
      EnD_o    = 1'b0;
      FlushE_o = 1'b1;
    end
  end

  // Wrapping performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      StallCycles_o <= '0;
      FlushCount_o  <= '0;
    end else begin
      if (!EnF_o)
        StallCycles_o <= StallCycles_o + CNT_WIDTH'(1);
      if (branch_taken)
        FlushCount_o <= FlushCount_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_WIDTH=4).
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic       RegWriteM_i, RegWriteW_i;
  logic [1:0] ResultSrcE_i;
  logic       PCSrcE_i, MemAccessM_i, MemAck_i;
  logic       MemReqValid_o, EnF_o, EnD_o, EnE_o, EnM_o;
  logic       FlushD_o, FlushE_o, FlushW_o, MemError_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic [3:0] StallCycles_o, FlushCount_o;

  hazard_ctrl #(.REGISTER_ADDR_SIZE(5), .TIMEOUT(4), .CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
    .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i),
    .MemAccessM_i(MemAccessM_i), .MemAck_i(MemAck_i),
    .MemReqValid_o(MemReqValid_o),
    .EnF_o(EnF_o), .EnD_o(EnD_o), .EnE_o(EnE_o), .EnM_o(EnM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemError_o(MemError_o),
    .StallCycles_o(StallCycles_o), .FlushCount_o(FlushCount_o)
  );

  always #5 clk_i = ~clk_i;

  // {EnF, EnD, EnE, EnM, FlushD, FlushE, FlushW}
  localparam logic [6:0] NORM = 7'b1111_000;
  localparam logic [6:0] LW   = 7'b0011_010;
  localparam logic [6:0] BR   = 7'b1111_110;
  localparam logic [6:0] MEM  = 7'b0000_001;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic [3:0] fwd;
    logic       req;
    logic       err;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] stall_exp = 4'd0;
  logic [3:0] flush_exp = 4'd0;
  logic       err_exp   = 1'b0;

  wire [6:0] ctl_o = {EnF_o, EnD_o, EnE_o, EnM_o, FlushD_o, FlushE_o, FlushW_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM_i && RdM_i != 5'd0 && RdM_i == rs) return 2'b10;
    if (RegWriteW_i && RdW_i != 5'd0 && RdW_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Push the expected outputs for the cycle whose inputs were just driven.
  task automatic exp_push(input string tag, input logic [6:0] ctl, input logic req,
                          input logic br);
    exp_t e;
    e.tag   = tag;
    e.ctl   = ctl;
    e.fwd   = {fwd_model(Rs1E_i), fwd_model(Rs2E_i)};
    e.req   = req;
    e.err   = err_exp;
    e.stall = stall_exp;
    e.flush = flush_exp;
    exp_q.push_back(e);
    if (!rst_i) begin
      if (!ctl[6]) stall_exp = stall_exp + 4'd1;
      if (br)      flush_exp = flush_exp + 4'd1;
    end
  endtask

  // Monitor: pops one expectation per cycle, mid low phase.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, ".ctl"},   32'(ctl_o),                      32'(e.ctl));
        check({e.tag, ".fwd"},   32'({ForwardAE_o, ForwardBE_o}), 32'(e.fwd));
        check({e.tag, ".req"},   32'(MemReqValid_o),              32'(e.req));
        check({e.tag, ".err"},   32'(MemError_o),                 32'(e.err));
        check({e.tag, ".stall"}, 32'(StallCycles_o),              32'(e.stall));
        check({e.tag, ".flush"}, 32'(FlushCount_o),               32'(e.flush));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    {Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i} = '0;
    {RegWriteM_i, RegWriteW_i, PCSrcE_i, MemAck_i} = '0;
    ResultSrcE_i = 2'b00;
    MemAccessM_i = 1'b1;

    // Reset: memory stall and request suppressed, branch still flushes
    tick(); exp_push("rst_mem", NORM, 1'b0, 1'b0);
    tick(); PCSrcE_i = 1'b1; exp_push("rst_br", BR, 1'b0, 1'b1);
    tick(); rst_i = 1'b0; MemAccessM_i = 1'b0; PCSrcE_i = 1'b0;
    exp_push("idle", NORM, 1'b0, 1'b0);

    // Forwarding priorities
    tick(); Rs1E_i = 5'd5; Rs2E_i = 5'd5; RdM_i = 5'd5; RegWriteM_i = 1'b1;
    RdW_i = 5'd5; RegWriteW_i = 1'b1; exp_push("fwd_m", NORM, 1'b0, 1'b0);
    tick(); RdM_i = 5'd0; exp_push("fwd_w", NORM, 1'b0, 1'b0);
    tick(); Rs2E_i = 5'd0; RdW_i = 5'd0; exp_push("fwd_none", NORM, 1'b0, 1'b0);
    tick(); Rs1E_i = 5'd9; Rs2E_i = 5'd9; RdM_i = 5'd9; RdW_i = 5'd9; RegWriteM_i = 1'b0;
    exp_push("fwd_wm0", NORM, 1'b0, 1'b0);
    tick(); RegWriteW_i = 1'b0; exp_push("fwd_nowe", NORM, 1'b0, 1'b0);
    tick(); RegWriteM_i = 1'b1; exp_push("fwd_m9", NORM, 1'b0, 1'b0);

    // Load-use
    tick(); RegWriteM_i = 1'b0; ResultSrcE_i = 2'b01; RdE_i = 5'd3; Rs2D_i = 5'd3;
    exp_push("lw_rs2", LW, 1'b0, 1'b0);
    tick(); ResultSrcE_i = 2'b00; exp_push("lw_after", NORM, 1'b0, 1'b0);
    tick(); ResultSrcE_i = 2'b01; RdE_i = 5'd0; exp_push("lw_x0", NORM, 1'b0, 1'b0);
    tick(); RdE_i = 5'd4; Rs1D_i = 5'd4; exp_push("lw_rs1", LW, 1'b0, 1'b0);
    tick(); ResultSrcE_i = 2'b10; exp_push("lw_notload", NORM, 1'b0, 1'b0);

    // Branch, and branch beating load-use
    tick(); ResultSrcE_i = 2'b00; PCSrcE_i = 1'b1; exp_push("br", BR, 1'b0, 1'b1);
    tick(); PCSrcE_i = 1'b0; exp_push("br_after", NORM, 1'b0, 1'b0);
    tick(); PCSrcE_i = 1'b1; ResultSrcE_i = 2'b01; exp_push("br_vs_lw", BR, 1'b0, 1'b1);
    tick(); PCSrcE_i = 1'b0; ResultSrcE_i = 2'b00; exp_push("br_done", NORM, 1'b0, 1'b0);

    // Memory wait, ack 3 cycles after request, branch held through the stall
    tick(); MemAccessM_i = 1'b1; PCSrcE_i = 1'b1; exp_push("mem_req", MEM, 1'b1, 1'b0);
    tick(); ResultSrcE_i = 2'b01; exp_push("mem_w1", MEM, 1'b0, 1'b0);
    tick(); ResultSrcE_i = 2'b00; exp_push("mem_w2", MEM, 1'b0, 1'b0);
    tick(); MemAck_i = 1'b1; exp_push("mem_ack", BR, 1'b0, 1'b1);
    // Back-to-back access requests in the cycle after release
    tick(); MemAck_i = 1'b0; PCSrcE_i = 1'b0; exp_push("b2b_req", MEM, 1'b1, 1'b0);
    tick(); MemAck_i = 1'b1; exp_push("b2b_ack", NORM, 1'b0, 1'b0);
    tick(); MemAccessM_i = 1'b0; exp_push("idle_ack", NORM, 1'b0, 1'b0);
    tick(); MemAck_i = 1'b0; exp_push("idle2", NORM, 1'b0, 1'b0);

    // Timeout: TIMEOUT+1 stalled cycles, then release with sticky error
    tick(); MemAccessM_i = 1'b1; exp_push("to_req", MEM, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); exp_push("to_wait", MEM, 1'b0, 1'b0);
    end
    tick(); exp_push("to_rel", NORM, 1'b0, 1'b0);
    err_exp = 1'b1;
    tick(); MemAccessM_i = 1'b0; exp_push("to_err", NORM, 1'b0, 1'b0);
    tick(); MemAck_i = 1'b1; exp_push("late_ack", NORM, 1'b0, 1'b0);
    tick(); MemAck_i = 1'b0; exp_push("err_hold", NORM, 1'b0, 1'b0);

    // Reset clears error and counters
    tick(); rst_i = 1'b1; err_exp = 1'b0; stall_exp = 4'd0; flush_exp = 4'd0;
    exp_push("rst_clr", NORM, 1'b0, 1'b0);
    tick(); rst_i = 1'b0; exp_push("post_rst", NORM, 1'b0, 1'b0);

    // Counter wrap: 17 stall cycles on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      tick(); ResultSrcE_i = 2'b01; RdE_i = 5'd3; Rs1D_i = 5'd3; Rs2D_i = 5'd0;
      exp_push("wrap_lw", LW, 1'b0, 1'b0);
    end
    tick(); ResultSrcE_i = 2'b00; exp_push("wrap_done", NORM, 1'b0, 1'b0);
    #3 check("wrap_cnt", 32'(StallCycles_o), 32'd1);

    // Reset in WAIT: back to IDLE, late ack ignored, new request issues
    tick(); MemAccessM_i = 1'b1; exp_push("rw_req", MEM, 1'b1, 1'b0);
    tick(); exp_push("rw_wait", MEM, 1'b0, 1'b0);
    tick(); rst_i = 1'b1; stall_exp = 4'd0; flush_exp = 4'd0;
    exp_push("rw_rst", NORM, 1'b0, 1'b0);
    tick(); rst_i = 1'b0; MemAccessM_i = 1'b0; MemAck_i = 1'b1;
    exp_push("rw_late_ack", NORM, 1'b0, 1'b0);
    tick(); MemAck_i = 1'b0; MemAccessM_i = 1'b1; exp_push("rw_idle_req", MEM, 1'b1, 1'b0);
    tick(); MemAck_i = 1'b1; exp_push("rw_ack", NORM, 1'b0, 1'b0);
    tick(); MemAck_i = 1'b0; MemAccessM_i = 1'b0; exp_push("rw_done", NORM, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    #4 check("drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
